seq_adders_tree: RTL and testbench

Sequential, handshaked counterpart of the combinational adders tree. It accepts one operand set (a, b, c, d) per transaction over a valid/ready input port. It computes sum1 = a+b, sum2 = c+d and sum3 = sum1+sum2 over three cycles using one shared adder, then presents the results on a valid/ready output port. It sits between an operand producer (stimulus or upstream datapath) and a result consumer, and replaces the wide parallel tree where area matters more than throughput.

---
 rtl/seq_adders_tree_if.sv | 30 +++
 rtl/seq_adders_tree.sv | 170 +++++++++++++++++
 tb/tb_seq_adders_tree.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seq_adders_tree_if.sv
// Operand/result handshake bundle for seq_adders_tree.
// The master side is the producer/consumer; the slave side is the block itself.
interface seq_adders_tree_if #(
   parameter int AW = 4,
   parameter int CW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] a;
   logic [AW-1:0] b;
   logic [CW-1:0] c;
   logic [CW-1:0] d;
   logic          out_valid;
   logic          out_ready;
   logic [AW:0]   sum1;
   logic [CW:0]   sum2;
   logic [CW+1:0] sum3;
   logic          busy;
   logic [7:0]    txn_cnt;

   modport master (
      output in_valid, a, b, c, d, out_ready,
      input  in_ready, out_valid, sum1, sum2, sum3, busy, txn_cnt
   );

   modport slave (
      input  in_valid, a, b, c, d, out_ready,
      output in_ready, out_valid, sum1, sum2, sum3, busy, txn_cnt
   );
endinterface

// File: rtl/seq_adders_tree.sv
// Sequential adders tree: sum1=a+b, sum2=c+d, sum3=sum1+sum2 over three cycles on one shared adder.
// Define SEQ_ADDERS_TREE_B2B_EN to let DONE accept the next operand set on the output handshake.
module seq_adders_tree #(
   parameter int AW = 4,
   parameter int CW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_adders_tree_if.slave     bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S2   = 3'd2,
      S3   = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] a_q, a_d, b_q, b_d;
   logic [CW-1:0] c_q, c_d, d_q, d_d;
   logic [AW:0]   sum1_q, sum1_d;
   logic [CW:0]   sum2_q, sum2_d;
   logic [CW+1:0] sum3_q, sum3_d;
   logic [7:0]    txn_cnt_q, txn_cnt_d;
   logic          out_valid_q, out_valid_d;
   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;

   logic [CW+1:0] add_a_s, add_b_s, add_sum_s;
   logic          in_ready_s, accept_s, out_hs_s;

   // Shared adder operand select; zero-extension to CW+2 rules out overflow.
   always_comb begin
      add_a_s = '0;
      add_b_s = '0;
      case (state_q)
         S1: begin
            add_a_s = {{(CW+2-AW){1'b0}}, a_q};
            add_b_s = {{(CW+2-AW){1'b0}}, b_q};
         end
         S2: begin
            add_a_s = {2'b00, c_q};
            add_b_s = {2'b00, d_q};
         end
         S3: begin
            add_a_s = {{(CW+1-AW){1'b0}}, sum1_q};
            add_b_s = {1'b0, sum2_q};
         end
         default: begin
            add_a_s = '0;
            add_b_s = '0;
         end
      endcase
      add_sum_s = add_a_s + add_b_s;
   end

`ifdef SEQ_ADDERS_TREE_B2B_EN
   assign in_ready_s = in_ready_q | ((state_q == DONE) & bus.out_ready);
`else
   assign in_ready_s = in_ready_q;
`endif
   assign accept_s = in_ready_s & bus.in_valid;
   assign out_hs_s = out_valid_q & bus.out_ready;

   // Next-state and datapath register updates.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      d_d       = d_q;
      sum1_d    = sum1_q;
      sum2_d    = sum2_q;
      sum3_d    = sum3_q;
      txn_cnt_d = txn_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               a_d     = bus.a;
               b_d     = bus.b;
               c_d     = bus.c;
               d_d     = bus.d;
               state_d = S1;
            end else begin
               state_d = IDLE;
            end
         end
         S1: begin
            sum1_d  = add_sum_s[AW:0];
            state_d = S2;
         end
         S2: begin
            sum2_d  = add_sum_s[CW:0];
            state_d = S3;
         end
         S3: begin
            sum3_d  = add_sum_s;
            state_d = DONE;
         end
         DONE: begin
            if (out_hs_s) begin
               txn_cnt_d = txn_cnt_q + 8'd1;
`ifdef SEQ_ADDERS_TREE_B2B_EN
               if (accept_s) begin
                  a_d     = bus.a;
                  b_d     = bus.b;
                  c_d     = bus.c;
                  d_d     = bus.d;
                  state_d = S1;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         sum1_q      <= '0;
         sum2_q      <= '0;
         sum3_q      <= '0;
         txn_cnt_q   <= 8'd0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         d_q         <= d_d;
         sum1_q      <= sum1_d;
         sum2_q      <= sum2_d;
         sum3_q      <= sum3_d;
         txn_cnt_q   <= txn_cnt_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.sum1      = sum1_q;
   assign bus.sum2      = sum2_q;
   assign bus.sum3      = sum3_q;
   assign bus.busy      = busy_q;
   assign bus.txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_seq_adders_tree.sv
// Directed bench for seq_adders_tree: inputs driven and outputs sampled on the falling edge.
module tb_seq_adders_tree;

   localparam int AW = 4;
   localparam int CW = 8;
`ifdef SEQ_ADDERS_TREE_B2B_EN
   localparam int SPACING = 4;
`else
   localparam int SPACING = 5;
`endif

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   exp_txn;

   seq_adders_tree_if #(.AW(AW), .CW(CW)) bus ();

   seq_adders_tree #(.AW(AW), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One transaction from IDLE: timeline checks, input scrambling while busy, optional stall.
   task automatic txn(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                      input logic [7:0] tc, input logic [7:0] td,
                      input int e1, input int e2, input int e3, input int stall);
      chk({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.a = ta; bus.b = tb_v; bus.c = tc; bus.d = td;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a = 4'd5; bus.b = 4'd6; bus.c = 8'd77; bus.d = 8'd200;
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      chk({tag, ".sum1"}, 32'(bus.sum1), 32'(e1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, ".sum2"}, 32'(bus.sum2), 32'(e2));
      chk({tag, ".ov_early"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk({tag, ".sum3"}, 32'(bus.sum3), 32'(e3));
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, ".stall_ov"}, 32'(bus.out_valid), 32'd1);
         chk({tag, ".stall_sum1"}, 32'(bus.sum1), 32'(e1));
         chk({tag, ".stall_sum3"}, 32'(bus.sum3), 32'(e3));
         chk({tag, ".stall_in_ready"}, 32'(bus.in_ready), 32'd0);
         chk({tag, ".stall_txn"}, 32'(bus.txn_cnt), 32'(exp_txn));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_txn = (exp_txn + 1) % 256;
      chk({tag, ".txn_cnt"}, 32'(bus.txn_cnt), 32'(exp_txn));
      chk({tag, ".ov_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".busy_drop"}, 32'(bus.busy), 32'd0);
      chk({tag, ".keep_sum2"}, 32'(bus.sum2), 32'(e2));
      chk({tag, ".keep_sum3"}, 32'(bus.sum3), 32'(e3));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      exp_txn = 0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
      @(negedge clk);
      do_reset();
      chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.sum3", 32'(bus.sum3), 32'd0);
      chk("rst.txn_cnt", 32'(bus.txn_cnt), 32'd0);

      // Abort in S2: sum1 already written, reset must clear it.
      bus.a = 4'd1; bus.b = 4'd1; bus.c = 8'd1; bus.d = 8'd1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("abort.sum1_pre", 32'(bus.sum1), 32'd2);
      do_reset();
      chk("abort.sum1", 32'(bus.sum1), 32'd0);
      chk("abort.sum2", 32'(bus.sum2), 32'd0);
      chk("abort.sum3", 32'(bus.sum3), 32'd0);
      chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort.busy", 32'(bus.busy), 32'd0);
      chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort.txn_cnt", 32'(bus.txn_cnt), 32'd0);

      txn("after_abort", 4'd0, 4'd9, 8'd45, 8'd45, 9, 90, 99, 0);
      txn("basic", 4'd0, 4'd3, 8'd1, 8'd255, 3, 256, 259, 0);
      txn("max", 4'd15, 4'd15, 8'd255, 8'd255, 30, 510, 540, 0);
      txn("backpressure", 4'd10, 4'd13, 8'd9, 8'd10, 23, 19, 42, 6);
      txn("ignore_busy", 4'd15, 4'd15, 8'd109, 8'd37, 30, 146, 176, 0);

      // Streaming: in_valid and out_ready held high, 257 handshakes.
      do_reset();
      exp_txn = 0;
      bus.a = 4'd1; bus.b = 4'd2; bus.c = 8'd3; bus.d = 8'd4;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      begin
         int cyc, last_cyc, n_hs;
         logic [7:0] prev;
         cyc = 0; last_cyc = 0; n_hs = 0; prev = 8'd0;
         while (n_hs < 257 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (bus.txn_cnt != prev) begin
               n_hs++;
               prev = bus.txn_cnt;
               if (n_hs > 1) chk("stream.spacing", 32'(cyc - last_cyc), 32'(SPACING));
               last_cyc = cyc;
            end
         end
         chk("stream.handshakes", 32'(n_hs), 32'd257);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("stream.txn_wrap", 32'(bus.txn_cnt), 32'd1);
      chk("stream.sum3", 32'(bus.sum3), 32'd10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
